branch_predictor: RTL and testbench

Bimodal branch direction predictor with a table of 2-bit saturating counters. Fetch sends a PC and gets a registered taken/not-taken prediction one cycle later. Execute returns each resolved outcome, the `branch_result` from the branch comparator, to train the table. The block also reports mispredicts and keeps saturating performance counters.

---
 rtl/branch_predictor_pkg.sv | 16 +
 rtl/sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 95 +++++++++
 tb/tb_branch_predictor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the bimodal branch predictor: architectural register width
// and the 2-bit saturating counter encoding.
package branch_predictor_pkg;

  typedef logic [31:0] arch_reg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_counter_t;

  localparam bht_counter_t BHT_RESET_STATE = WEAK_NT;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state of a 2-bit saturating direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bht_counter_t cur,
  input  logic         taken,
  output bht_counter_t next
);

  always_comb begin
    next = cur;
    unique case (cur)
      STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  next = taken ? STRONG_T : WEAK_T;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit counters, registered prediction,
// mispredict flag and saturating performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned INDEX_BITS  = $clog2(BHT_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  arch_reg     pred_pc,
  output logic        pred_resp_valid,
  output logic        pred_resp_taken,
  input  logic        upd_valid,
  input  arch_reg     upd_pc,
  input  logic        upd_taken,
  input  logic        upd_predicted,
  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  bht_counter_t bht_q [BHT_ENTRIES];

  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  bht_counter_t          upd_next;
  logic                  pred_taken_d;
  logic                  mispredict_d;
  logic [31:0]           branch_count_d;
  logic [31:0]           mispredict_count_d;
  logic                  unused_pc;

  assign pred_idx = pred_pc[INDEX_BITS+1:2];
  assign upd_idx  = upd_pc[INDEX_BITS+1:2];
  // Upper PC bits alias by design; low two bits are always ignored.
  assign unused_pc = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                       upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

  sat_counter2 u_sat_counter2 (
    .cur   (bht_q[upd_idx]),
    .taken (upd_taken),
    .next  (upd_next)
  );

  always_comb begin
    pred_taken_d = bht_q[pred_idx][1];
    // Same-cycle update to the same entry: forward the value being written.
    if (upd_valid && (upd_idx == pred_idx)) begin
      pred_taken_d = upd_next[1];
    end
  end

  always_comb begin
    mispredict_d       = upd_valid && (upd_taken != upd_predicted);
    branch_count_d     = branch_count;
    mispredict_count_d = mispredict_count;
    if (upd_valid && (branch_count != 32'hFFFF_FFFF)) begin
      branch_count_d = branch_count + 32'd1;
    end
    if (mispredict_d && (mispredict_count != 32'hFFFF_FFFF)) begin
      mispredict_count_d = mispredict_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BHT_RESET_STATE;
      end
    end else if (upd_valid) begin
      bht_q[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_resp_valid  <= 1'b0;
      pred_resp_taken  <= 1'b0;
      mispredict       <= 1'b0;
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      pred_resp_valid  <= pred_valid;
      if (pred_valid) begin
        pred_resp_taken <= pred_taken_d;
      end
      mispredict       <= mispredict_d;
      branch_count     <= branch_count_d;
      mispredict_count <= mispredict_count_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (BHT_ENTRIES = 64).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_resp_valid;
  logic        pred_resp_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_predicted;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int unsigned n_pass;
  int unsigned n_total;

  branch_predictor #(
    .BHT_ENTRIES (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_resp_valid  (pred_resp_valid),
    .pred_resp_taken  (pred_resp_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_predicted    (upd_predicted),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic predict(input logic [31:0] pc);
    pred_valid = 1'b1;
    pred_pc    = pc;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic predicted);
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_taken     = taken;
    upd_predicted = predicted;
  endtask

  task automatic check_counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    check({tag, ".branch_count"}, branch_count, bc);
    check({tag, ".mispredict_count"}, mispredict_count, mc);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_predicted = 1'b0;
    predict(32'h100);
    step(); step();
    check("rst.resp_valid", {31'd0, pred_resp_valid}, 32'd0);
    check("rst.resp_taken", {31'd0, pred_resp_taken}, 32'd0);
    check("rst.mispredict", {31'd0, mispredict}, 32'd0);
    check_counts("rst", 32'd0, 32'd0);
    rst = 1'b0;
    idle();
    step();

    // Fresh entry is WEAK_NT -> not taken.
    predict(32'h100); step();
    check("init.resp_valid", {31'd0, pred_resp_valid}, 32'd1);
    check("init.resp_taken", {31'd0, pred_resp_taken}, 32'd0);
    check_counts("init", 32'd0, 32'd0);
    idle(); step();
    check("idle.resp_valid", {31'd0, pred_resp_valid}, 32'd0);

    // Mispredict pulse on idx 2.
    update(32'h108, 1'b1, 1'b0); step();
    check("mp.mispredict", {31'd0, mispredict}, 32'd1);
    check_counts("mp", 32'd1, 32'd1);
    idle(); step();
    check("mp.pulse_end", {31'd0, mispredict}, 32'd0);
    check_counts("mp.hold", 32'd1, 32'd1);
    update(32'h108, 1'b1, 1'b1); step();
    check("match.mispredict", {31'd0, mispredict}, 32'd0);
    check_counts("match", 32'd2, 32'd1);

    // Back-to-back taken updates chain: WEAK_NT -> WEAK_T -> STRONG_T -> STRONG_T.
    update(32'h100, 1'b1, 1'b1); step();
    update(32'h100, 1'b1, 1'b1); step();
    update(32'h100, 1'b1, 1'b1); step();
    idle(); predict(32'h100); step();
    check("train3.taken", {31'd0, pred_resp_taken}, 32'd1);
    check_counts("train3", 32'd5, 32'd1);
    idle(); update(32'h100, 1'b0, 1'b1); step();
    check("nt.mispredict", {31'd0, mispredict}, 32'd1);
    check_counts("nt", 32'd6, 32'd2);
    idle(); predict(32'h100); step();
    check("weak_t.taken", {31'd0, pred_resp_taken}, 32'd1);

    // Aliasing: 0x200 shares index 0 with 0x100; 0x104 is index 1.
    idle(); update(32'h100, 1'b1, 1'b1); step();
    update(32'h100, 1'b1, 1'b1); step();
    idle(); predict(32'h200); step();
    check("alias.0x200", {31'd0, pred_resp_taken}, 32'd1);
    predict(32'h104); step();
    check("alias.0x104", {31'd0, pred_resp_taken}, 32'd0);
    check_counts("alias", 32'd8, 32'd2);

    // Same-cycle bypass on idx 3 (WEAK_NT -> WEAK_T).
    idle(); update(32'h10C, 1'b1, 1'b0); predict(32'h10C); step();
    check("bypass.valid", {31'd0, pred_resp_valid}, 32'd1);
    check("bypass.taken", {31'd0, pred_resp_taken}, 32'd1);
    // Different indices in the same cycle stay independent.
    update(32'h110, 1'b1, 1'b0); predict(32'h114); step();
    check("indep.taken", {31'd0, pred_resp_taken}, 32'd0);
    check_counts("bypass", 32'd10, 32'd4);
    idle(); predict(32'h110); step();
    check("after_upd.taken", {31'd0, pred_resp_taken}, 32'd1);

    // Asynchronous reset mid-cycle with a taken response in flight.
    predict(32'h100); step();
    check("pre_rst.taken", {31'd0, pred_resp_taken}, 32'd1);
    update(32'h100, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst.resp_valid", {31'd0, pred_resp_valid}, 32'd0);
    check("arst.resp_taken", {31'd0, pred_resp_taken}, 32'd0);
    check("arst.mispredict", {31'd0, mispredict}, 32'd0);
    check_counts("arst", 32'd0, 32'd0);
    step(); step();
    check("arst.held_valid", {31'd0, pred_resp_valid}, 32'd0);
    check_counts("arst.held", 32'd0, 32'd0);
    idle();
    rst = 1'b0;
    predict(32'h100); step();
    check("post_rst.valid", {31'd0, pred_resp_valid}, 32'd1);
    check("post_rst.0x100", {31'd0, pred_resp_taken}, 32'd0);
    predict(32'h110); step();
    check("post_rst.0x110", {31'd0, pred_resp_taken}, 32'd0);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
